if_id_skid_stage: RTL and testbench
===================================

Name: if_id_skid_stage

Overview:
- Parametrised IF/ID boundary register between the fetch unit and the decoder, replacing the free-running PC/IR latch.
- Adds a ready/valid handshake on both sides, a 2-entry skid buffer so backpressure never loses a fetched instruction, synchronous flush with NOP injection, and saturating stall/flush performance counters.
- All state updates on the negative edge of clk, matching the rest of the pipeline registers.

Parameters:
PC_W, 32, width of program counter field
IR_W, 32, width of instruction field
NOP_INSTR, 32'h0000_0000, value driven on ir_out when no valid instruction is held (IR_W bits)
CNT_W, 16, width of performance counters

Ports:
clk  input  1  pipeline clock; all registers update on negedge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  fetch presents a beat
in_ready  output  1  stage can accept a beat (registered)
pc_in  input  PC_W  fetched PC
ir_in  input  IR_W  fetched instruction
out_valid  output  1  decode-side beat valid
out_ready  input  1  decoder accepts beat
pc_out  output  PC_W  PC of head entry
ir_out  output  IR_W  instruction of head entry, NOP_INSTR when empty/flushed
flush  input  1  discard all held and incoming beats (branch/exception redirect)
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
flush_cnt  output  CNT_W  clock edges with flush=1, saturating

Behaviour:
- Reset (rst_n=0, async): state=EMPTY, out_valid=0, in_ready=1, pc_out=0, ir_out=NOP_INSTR, skid entry=0, stall_cnt=0, flush_cnt=0. Reset mid-transfer discards all entries.
- accept = in_valid & in_ready; fire = out_valid & out_ready; both sampled at negedge.
- Head register (pc_out/ir_out) is the output directly: latency 1 edge from accept to out_valid when EMPTY.
- States (occupancy): EMPTY (0), FULL (1, head only), SKID (2, head + skid).
  - EMPTY: accept -> FULL, head<=in.
  - FULL: accept&fire -> FULL, head<=in; accept&!fire -> SKID, skid<=in; !accept&fire -> EMPTY, ir_out<=NOP_INSTR, pc_out holds; else hold.
  - SKID: in_ready=0, so no accept; fire -> FULL, head<=skid; else hold.
- in_ready is registered: 1 in EMPTY/FULL, 0 in SKID; computed from next state.
- out_valid = (state != EMPTY).
- Head and skid contents are never altered while not consumed (stable under backpressure).
- Flush has priority over everything: next state=EMPTY, out_valid=0, in_ready=1, ir_out=NOP_INSTR, pc_out holds last value; any same-edge incoming beat is discarded even if in_valid & in_ready; same-edge fire is treated as completed by the decoder (no replay).
- stall_cnt: +1 at each edge where out_valid & !out_ready & !flush; holds at 2^CNT_W-1.
- flush_cnt: +1 at each edge where flush=1; holds at 2^CNT_W-1.
- Counters are cleared only by reset.
- No combinational path from out_ready to in_ready.

Test Plan:
- Streaming: out_ready=1, in_valid=1, pc_in 0x0,0x4,0x8 with ir_in 0x11,0x22,0x33 -> out_valid rises 1 edge after the first beat; pc_out/ir_out follow 0x0/0x11, 0x4/0x22, 0x8/0x33 on consecutive edges; stall_cnt=0.
- Backpressure: send 0x100/0xAA then 0x104/0xBB with out_ready=0 -> after 2nd edge in_ready=0, ir_out=0xAA held; stall_cnt counts 1 per edge; raise out_ready -> 0xAA, then 0xBB, then out_valid=0, ir_out=NOP_INSTR; no beat lost or duplicated.
- Flush in SKID with in_valid=1 and pc_in 0x200 -> next edge out_valid=0, in_ready=1, ir_out=NOP_INSTR, flush_cnt=1; 0x200 never appears on pc_out.
- Async reset asserted mid-stream between edges -> outputs immediately at reset values (ir_out=NOP_INSTR, in_ready=1, counters 0); after release, first accepted beat appears 1 edge later.
- Saturation with CNT_W=4: hold out_ready=0 with a valid beat for 20 edges -> stall_cnt stops at 15; pulse flush 18 times -> flush_cnt=15.

Source files
------------

// File: rtl/if_id_skid_stage.sv
// rtl/if_id_skid_stage.sv - IF/ID pipeline register with ready/valid, 2-entry skid, flush and perf counters
module if_id_skid_stage #(
    parameter int          PC_W      = 32,
    parameter int          IR_W      = 32,
    parameter logic [IR_W-1:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  pc_in,
    input  logic [IR_W-1:0]  ir_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  pc_out,
    output logic [IR_W-1:0]  ir_out,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   head_pc_q, head_pc_d;
    logic [IR_W-1:0]   head_ir_q, head_ir_d;
    logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
    logic [IR_W-1:0]   skid_ir_q, skid_ir_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic accept;
    logic fire;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign pc_out    = head_pc_q;
    assign ir_out    = head_ir_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    assign accept = in_valid & in_ready_q;
    assign fire   = out_valid & out_ready;

    always_comb begin
        state_d   = state_q;
        head_pc_d = head_pc_q;
        head_ir_d = head_ir_q;
        skid_pc_d = skid_pc_q;
        skid_ir_d = skid_ir_q;

        if (flush) begin
            // pc_out keeps its last value so a redirect leaves a traceable PC
            state_d   = EMPTY;
            head_ir_d = NOP_INSTR;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d   = FULL;
                        head_pc_d = pc_in;
                        head_ir_d = ir_in;
                    end
                end
                FULL: begin
                    if (accept && fire) begin
                        head_pc_d = pc_in;
                        head_ir_d = ir_in;
                    end else if (accept) begin
                        state_d   = SKID;
                        skid_pc_d = pc_in;
                        skid_ir_d = ir_in;
                    end else if (fire) begin
                        state_d   = EMPTY;
                        head_ir_d = NOP_INSTR;
                    end
                end
                SKID: begin
                    if (fire) begin
                        state_d   = FULL;
                        head_pc_d = skid_pc_q;
                        head_ir_d = skid_ir_q;
                    end
                end
                default: begin
                    state_d   = EMPTY;
                    head_ir_d = NOP_INSTR;
                end
            endcase
        end

        // registered from next state, so out_ready never reaches in_ready combinationally
        in_ready_d = (state_d != SKID);

        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;

        flush_cnt_d = flush_cnt_q;
        if (flush && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            head_pc_q   <= '0;
            head_ir_q   <= NOP_INSTR;
            skid_pc_q   <= '0;
            skid_ir_q   <= '0;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            head_pc_q   <= head_pc_d;
            head_ir_q   <= head_ir_d;
            skid_pc_q   <= skid_pc_d;
            skid_ir_q   <= skid_ir_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// tb/tb_if_id_skid_stage.sv - directed vector bench for if_id_skid_stage
module tb_if_id_skid_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, flush;
    logic [31:0] pc_in, ir_in, pc_out, ir_out;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_flush;
    logic [31:0] s_pc_in, s_ir_in, s_pc_out, s_ir_out;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int total = 0;
    int bad   = 0;

    if_id_skid_stage #(.PC_W(32), .IR_W(32), .NOP_INSTR(NOP), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .ir_in(ir_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .ir_out(ir_out),
        .flush(flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    if_id_skid_stage #(.PC_W(32), .IR_W(32), .NOP_INSTR(NOP), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .pc_in(s_pc_in), .ir_in(s_ir_in),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .pc_out(s_pc_out), .ir_out(s_ir_out),
        .flush(s_flush),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        iv;
        logic        ordy;
        logic [31:0] pc;
        logic [31:0] ir;
        logic        e_ov;
        logic        e_rdy;
        logic [31:0] e_pc;
        logic [31:0] e_ir;
        logic [15:0] e_st;
        logic [15:0] e_fl;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // inputs are driven just after posedge; DUT updates on negedge; outputs are sampled at next posedge
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic check_main(input string tag, input logic ov, input logic rdy,
                              input logic [31:0] pc, input logic [31:0] ir,
                              input logic [15:0] st, input logic [15:0] fc);
        chk({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, ov});
        chk({tag, ".in_ready"},  {63'd0, in_ready},  {63'd0, rdy});
        chk({tag, ".pc_out"},    {32'd0, pc_out},    {32'd0, pc});
        chk({tag, ".ir_out"},    {32'd0, ir_out},    {32'd0, ir});
        chk({tag, ".stall_cnt"}, {48'd0, stall_cnt}, {48'd0, st});
        chk({tag, ".flush_cnt"}, {48'd0, flush_cnt}, {48'd0, fc});
    endtask

    initial begin
        //          fl  iv  ordy pc            ir            ov  rdy  pc_out        ir_out        stall flush
        // streaming
        vt[0]  = '{1'b0,1'b1,1'b1,32'h0,      32'h11, 1'b1,1'b1,32'h0,      32'h11, 16'd0,16'd0};
        vt[1]  = '{1'b0,1'b1,1'b1,32'h4,      32'h22, 1'b1,1'b1,32'h4,      32'h22, 16'd0,16'd0};
        vt[2]  = '{1'b0,1'b1,1'b1,32'h8,      32'h33, 1'b1,1'b1,32'h8,      32'h33, 16'd0,16'd0};
        vt[3]  = '{1'b0,1'b0,1'b1,32'h0,      32'h0,  1'b0,1'b1,32'h8,      NOP,    16'd0,16'd0};
        // backpressure into skid and drain
        vt[4]  = '{1'b0,1'b1,1'b0,32'h100,    32'hAA, 1'b1,1'b1,32'h100,    32'hAA, 16'd0,16'd0};
        vt[5]  = '{1'b0,1'b1,1'b0,32'h104,    32'hBB, 1'b1,1'b0,32'h100,    32'hAA, 16'd1,16'd0};
        vt[6]  = '{1'b0,1'b1,1'b0,32'h108,    32'hCC, 1'b1,1'b0,32'h100,    32'hAA, 16'd2,16'd0};
        vt[7]  = '{1'b0,1'b0,1'b1,32'h0,      32'h0,  1'b1,1'b1,32'h104,    32'hBB, 16'd2,16'd0};
        vt[8]  = '{1'b0,1'b0,1'b1,32'h0,      32'h0,  1'b0,1'b1,32'h104,    NOP,    16'd2,16'd0};
        // flush while in SKID with an incoming beat
        vt[9]  = '{1'b0,1'b1,1'b0,32'h300,    32'h44, 1'b1,1'b1,32'h300,    32'h44, 16'd2,16'd0};
        vt[10] = '{1'b0,1'b1,1'b0,32'h304,    32'h55, 1'b1,1'b0,32'h300,    32'h44, 16'd3,16'd0};
        vt[11] = '{1'b1,1'b1,1'b0,32'h200,    32'h66, 1'b0,1'b1,32'h300,    NOP,    16'd3,16'd1};
        vt[12] = '{1'b0,1'b0,1'b1,32'h0,      32'h0,  1'b0,1'b1,32'h300,    NOP,    16'd3,16'd1};
        // flush in FULL with same-edge accept and fire
        vt[13] = '{1'b0,1'b1,1'b1,32'h400,    32'h77, 1'b1,1'b1,32'h400,    32'h77, 16'd3,16'd1};
        vt[14] = '{1'b1,1'b1,1'b1,32'h404,    32'h88, 1'b0,1'b1,32'h400,    NOP,    16'd3,16'd2};
        vt[15] = '{1'b0,1'b1,1'b1,32'h408,    32'h99, 1'b1,1'b1,32'h408,    32'h99, 16'd3,16'd2};
        vt[16] = '{1'b0,1'b0,1'b0,32'h0,      32'h0,  1'b1,1'b1,32'h408,    32'h99, 16'd4,16'd2};

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; pc_in = '0; ir_in = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_flush = 1'b0; s_pc_in = '0; s_ir_in = '0;
        repeat (2) @(posedge clk);
        check_main("reset", 1'b0, 1'b1, 32'h0, NOP, 16'd0, 16'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            flush     = vt[i].fl;
            in_valid  = vt[i].iv;
            out_ready = vt[i].ordy;
            pc_in     = vt[i].pc;
            ir_in     = vt[i].ir;
            tick();
            check_main($sformatf("vec%0d", i), vt[i].e_ov, vt[i].e_rdy,
                       vt[i].e_pc, vt[i].e_ir, vt[i].e_st, vt[i].e_fl);
        end

        // async reset between edges while holding a beat: outputs drop at once
        in_valid = 1'b1; out_ready = 1'b0; pc_in = 32'h50C; ir_in = 32'hEE;
        rst_n = 1'b0;
        #1;
        check_main("async_rst", 1'b0, 1'b1, 32'h0, NOP, 16'd0, 16'd0);
        @(posedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1; pc_in = 32'h500; ir_in = 32'hAB;
        tick();
        check_main("post_rst", 1'b1, 1'b1, 32'h500, 32'hAB, 16'd0, 16'd0);
        in_valid = 1'b0;

        // saturation on the 4-bit counter instance
        s_in_valid = 1'b1; s_pc_in = 32'h600; s_ir_in = 32'h5A; s_out_ready = 1'b0;
        tick();
        s_in_valid = 1'b0;
        chk("sat.accept_ir", {32'd0, s_ir_out}, {32'd0, 32'h5A});
        chk("sat.stall_start", {60'd0, s_stall_cnt}, 64'd0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) chk("sat.stall14", {60'd0, s_stall_cnt}, 64'd14);
        end
        chk("sat.stall_max", {60'd0, s_stall_cnt}, 64'd15);
        chk("sat.head_stable", {32'd0, s_ir_out}, {32'd0, 32'h5A});
        for (int i = 1; i <= 18; i++) begin
            s_flush = 1'b1;
            tick();
            s_flush = 1'b0;
            tick();
            if (i == 14) chk("sat.flush14", {60'd0, s_flush_cnt}, 64'd14);
        end
        chk("sat.flush_max", {60'd0, s_flush_cnt}, 64'd15);
        chk("sat.stall_hold", {60'd0, s_stall_cnt}, 64'd15);
        chk("sat.flushed_empty", {63'd0, s_out_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
